// File: rtl/unified_mem_arbiter_if.sv
// Bundle of the fetch port, data port and memory-side bus shared by the unified memory arbiter.
// The slave modport is the arbiter's view; master is the pipeline-and-memory side.
interface unified_mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              i_req;
    logic [ADDR_W-1:0] i_addr;
    logic              i_flush;
    logic [DATA_W-1:0] i_rdata;
    logic              i_valid;

    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic [DATA_W-1:0] d_rdata;
    logic              d_valid;

    logic              m_req;
    logic              m_we;
    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] m_wdata;
    logic              m_ready;
    logic [DATA_W-1:0] m_rdata;

    logic              stall_F;
    logic              stall_M;

    modport slave (
        input  i_req, i_addr, i_flush,
        output i_rdata, i_valid,
        input  d_req, d_we, d_addr, d_wdata,
        output d_rdata, d_valid,
        output m_req, m_we, m_addr, m_wdata,
        input  m_ready, m_rdata,
        output stall_F, stall_M
    );

    modport master (
        output i_req, i_addr, i_flush,
        input  i_rdata, i_valid,
        output d_req, d_we, d_addr, d_wdata,
        input  d_rdata, d_valid,
        input  m_req, m_we, m_addr, m_wdata,
        output m_ready, m_rdata,
        input  stall_F, stall_M
    );
endinterface

// File: rtl/unified_mem_arbiter.sv
// Arbitrates one single-port memory between the fetch and data ports: data has priority,
// but a saturating wait counter forces fetch through after MAX_WAIT consecutive data grants.
module unified_mem_arbiter #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = 4
) (
    input logic                  clk,
    input logic                  rst,
    unified_mem_arbiter_if.slave bus
);
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] BUSY_I = 2'd1;
    localparam logic [1:0] BUSY_D = 2'd2;
    localparam logic [1:0] RESP   = 2'd3;

    localparam logic [3:0] WAIT_LIMIT = 4'(MAX_WAIT);

    logic [1:0]        state;
    logic              owner_i;
    logic              kill;
    logic [3:0]        wait_cnt;
    logic              m_req_r;
    logic              m_we_r;
    logic [ADDR_W-1:0] m_addr_r;
    logic [DATA_W-1:0] m_wdata_r;
    logic [DATA_W-1:0] i_rdata_r;
    logic [DATA_W-1:0] d_rdata_r;
    logic              grant_d;
    logic              grant_i;
    logic              i_valid_c;
    logic              d_valid_c;

    always_comb begin
        grant_d = bus.d_req && !(bus.i_req && (wait_cnt >= WAIT_LIMIT));
        grant_i = !grant_d && bus.i_req;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            owner_i   <= 1'b0;
            kill      <= 1'b0;
            m_req_r   <= 1'b0;
            m_we_r    <= 1'b0;
            m_addr_r  <= '0;
            m_wdata_r <= '0;
            i_rdata_r <= '0;
            d_rdata_r <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_d) begin
                        state     <= BUSY_D;
                        owner_i   <= 1'b0;
                        m_req_r   <= 1'b1;
                        m_we_r    <= bus.d_we;
                        m_addr_r  <= bus.d_addr;
                        m_wdata_r <= bus.d_wdata;
                    end else if (grant_i) begin
                        state     <= BUSY_I;
                        owner_i   <= 1'b1;
                        m_req_r   <= 1'b1;
                        m_we_r    <= 1'b0;
                        m_addr_r  <= bus.i_addr;
                        m_wdata_r <= '0;
                        if (bus.i_flush) begin
                            kill <= 1'b1;
                        end
                    end
                end
                BUSY_I, BUSY_D: begin
                    // A branch taken while the fetch is in flight must kill its response.
                    if (state == BUSY_I && bus.i_flush) begin
                        kill <= 1'b1;
                    end
                    if (bus.m_ready) begin
                        state   <= RESP;
                        m_req_r <= 1'b0;
                        m_we_r  <= 1'b0;
                        if (state == BUSY_I) begin
                            i_rdata_r <= bus.m_rdata;
                        end else if (!m_we_r) begin
                            d_rdata_r <= bus.m_rdata;
                        end
                    end
                end
                RESP: begin
                    state <= IDLE;
                    kill  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt <= '0;
        end else if (!bus.i_req) begin
            wait_cnt <= '0;
        end else if (state == IDLE && grant_d) begin
            if (wait_cnt != 4'hF) begin
                wait_cnt <= wait_cnt + 4'd1;
            end
        end else if (state == IDLE && grant_i) begin
            wait_cnt <= '0;
        end
    end

    // The fetch pulse also honours a flush arriving in the response cycle itself.
    assign i_valid_c   = (state == RESP) && owner_i && !kill && !bus.i_flush;
    assign d_valid_c   = (state == RESP) && !owner_i;

    assign bus.i_valid = i_valid_c;
    assign bus.d_valid = d_valid_c;
    assign bus.i_rdata = i_rdata_r;
    assign bus.d_rdata = d_rdata_r;
    assign bus.m_req   = m_req_r;
    assign bus.m_we    = m_we_r;
    assign bus.m_addr  = m_addr_r;
    assign bus.m_wdata = m_wdata_r;
    assign bus.stall_F = bus.i_req && !i_valid_c;
    assign bus.stall_M = bus.d_req && !d_valid_c;
endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Scoreboard bench for unified_mem_arbiter: a word-array reference model predicts every response,
// a memory responder serves the bus, and a monitor pops expectations on each valid pulse.
module tb_unified_mem_arbiter;
    localparam int ADDR_W   = 32;
    localparam int DATA_W   = 32;
    localparam int MAX_WAIT = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    unified_mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    unified_mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_WAIT(MAX_WAIT)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int          compared = 0;
    int          mismatched = 0;
    logic [31:0] mem_arr [0:255];
    logic [31:0] ref_mem [0:255];
    logic [31:0] i_exp_q [$];
    logic [31:0] d_exp_q [$];
    logic [31:0] last_load = 32'h0;
    int          force_lat = 0;
    int          mreq_cycles = 0;
    bit          grant_log [$];
    bit          i_req_e = 1'b0;
    bit          d_req_e = 1'b0;

    function automatic logic [31:0] init_word(input int i);
        if (i == 4) return 32'h00500093;
        return 32'(i * 32'h9E3779B1) ^ 32'h1234_5678;
    endfunction

    task automatic checkOutput(input string name, input logic [127:0] actual, input logic [127:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, want 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Drive one request and record what the reference model says it must return.
    task automatic applyStimulus(input bit is_data, input bit we, input logic [31:0] addr,
                                 input logic [31:0] wdata, input bit expect_resp);
        if (is_data) begin
            bus.d_req   = 1'b1;
            bus.d_we    = we;
            bus.d_addr  = addr;
            bus.d_wdata = wdata;
            if (we) ref_mem[addr[9:2]] = wdata;
            else    last_load = ref_mem[addr[9:2]];
            d_exp_q.push_back(last_load);
        end else begin
            bus.i_req  = 1'b1;
            bus.i_addr = addr;
            if (expect_resp) i_exp_q.push_back(ref_mem[addr[9:2]]);
        end
    endtask

    task automatic finishRequest(input bit is_data, input string name);
        int n = 0;
        bit seen = 1'b0;
        while (!seen && n < 200) begin
            @(negedge clk);
            n++;
            seen = is_data ? bus.d_valid : bus.i_valid;
        end
        if (!seen) checkOutput({name, "_timeout"}, 0, 1);
        if (is_data) bus.d_req = 1'b0;
        else         bus.i_req = 1'b0;
    endtask

    task automatic waitFetchMreq(input logic [31:0] addr, input string name);
        int n = 0;
        bit seen = 1'b0;
        while (!seen && n < 200) begin
            @(negedge clk);
            n++;
            seen = bus.m_req && !bus.m_we && (bus.m_addr == addr);
        end
        if (!seen) checkOutput({name, "_timeout"}, 0, 1);
    endtask

    task automatic fetchDriver(input int count);
        for (int k = 0; k < count; k++) begin
            int          gap;
            logic [31:0] a;
            bit          fl;
            gap = $urandom_range(1, 4);
            a   = {22'd0, 8'($urandom_range(0, 127)), 2'b00};
            fl  = ($urandom_range(0, 4) == 0);
            repeat (gap) @(negedge clk);
            applyStimulus(1'b0, 1'b0, a, 32'h0, !fl);
            if (fl) begin
                waitFetchMreq(a, "rand_flush");
                bus.i_flush = 1'b1;
                @(negedge clk);
                bus.i_flush = 1'b0;
                bus.i_req   = 1'b0;
            end else begin
                finishRequest(1'b0, "rand_fetch");
            end
        end
    endtask

    task automatic dataDriver(input int count);
        for (int k = 0; k < count; k++) begin
            int          gap;
            logic [31:0] a;
            gap = $urandom_range(1, 3);
            a   = {22'd0, 8'($urandom_range(128, 255)), 2'b00};
            repeat (gap) @(negedge clk);
            applyStimulus(1'b1, 1'($urandom_range(0, 1)), a, $urandom, 1'b1);
            finishRequest(1'b1, "rand_data");
        end
    endtask

    always @(posedge clk) begin
        i_req_e <= bus.i_req;
        d_req_e <= bus.d_req;
    end

    // Memory responder: serves m_req with a chosen latency, checks the bus holds still while
    // waiting, and checks every grant against the priority/starvation rule.
    initial begin
        bit           busy;
        int           lat;
        int           streak;
        logic [64:0]  held;
        bit           exp_fetch;
        busy   = 1'b0;
        lat    = 0;
        streak = 0;
        held   = '0;
        for (int i = 0; i < 256; i++) mem_arr[i] = init_word(i);
        bus.m_ready = 1'b0;
        bus.m_rdata = '0;
        forever begin
            @(negedge clk);
            bus.m_ready = 1'b0;
            bus.m_rdata = $urandom;
            if (rst) begin
                busy   = 1'b0;
                streak = 0;
                continue;
            end
            if (!i_req_e) streak = 0;
            if (bus.m_req) begin
                if (!busy) begin
                    busy      = 1'b1;
                    lat       = (force_lat >= 0) ? force_lat : $urandom_range(0, 3);
                    held      = {bus.m_we, bus.m_addr, bus.m_wdata};
                    exp_fetch = !(d_req_e && !(i_req_e && streak >= MAX_WAIT));
                    if (exp_fetch) begin
                        checkOutput("grant_fetch", {bus.m_we, bus.m_addr}, {1'b0, bus.i_addr});
                        streak = 0;
                    end else begin
                        checkOutput("grant_data", {bus.m_we, bus.m_addr, bus.m_wdata},
                                    {bus.d_we, bus.d_addr, bus.d_wdata});
                        if (i_req_e && streak < 15) streak++;
                    end
                    grant_log.push_back(!bus.m_we && bus.i_req && (bus.m_addr == bus.i_addr));
                end else begin
                    checkOutput("m_bus_stable", {bus.m_we, bus.m_addr, bus.m_wdata}, held);
                end
                mreq_cycles++;
                if (lat == 0) begin
                    bus.m_ready = 1'b1;
                    if (bus.m_we) mem_arr[bus.m_addr[9:2]] = bus.m_wdata;
                    else          bus.m_rdata = mem_arr[bus.m_addr[9:2]];
                    busy = 1'b0;
                end else begin
                    lat--;
                end
            end else if (busy) begin
                checkOutput("m_req_held", 0, 1);
                busy = 1'b0;
            end
        end
    end

    // Monitor: every valid pulse must match the oldest expectation for its port.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (bus.i_valid) begin
                    if (i_exp_q.size() == 0) checkOutput("i_valid_unexpected", 1, 0);
                    else checkOutput("i_rdata", bus.i_rdata, i_exp_q.pop_front());
                end
                if (bus.d_valid) begin
                    if (d_exp_q.size() == 0) checkOutput("d_valid_unexpected", 1, 0);
                    else checkOutput("d_rdata", bus.d_rdata, d_exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
        bus.i_req   = 1'b0;
        bus.i_addr  = '0;
        bus.i_flush = 1'b0;
        bus.d_req   = 1'b0;
        bus.d_we    = 1'b0;
        bus.d_addr  = '0;
        bus.d_wdata = '0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checkOutput("reset_m_req", bus.m_req, 0);
        checkOutput("reset_valids", {bus.i_valid, bus.d_valid}, 0);
        checkOutput("reset_m_addr_wdata", {bus.m_addr, bus.m_wdata, bus.m_we}, 0);
        checkOutput("reset_rdata", {bus.i_rdata, bus.d_rdata}, 0);
        rst = 1'b0;
        @(negedge clk);

        $display("[TB] lone fetch");
        force_lat = 0;
        applyStimulus(1'b0, 1'b0, 32'h10, 32'h0, 1'b1);
        @(negedge clk);
        checkOutput("lone_m_req", bus.m_req, 1);
        checkOutput("lone_m_addr_we", {bus.m_addr, bus.m_we}, {32'h10, 1'b0});
        checkOutput("lone_stall_F_busy", bus.stall_F, 1);
        @(negedge clk);
        checkOutput("lone_i_valid", bus.i_valid, 1);
        checkOutput("lone_i_rdata", bus.i_rdata, 32'h00500093);
        checkOutput("lone_stall_F_done", bus.stall_F, 0);
        bus.i_req = 1'b0;
        @(negedge clk);
        checkOutput("lone_i_valid_pulse", bus.i_valid, 0);

        $display("[TB] store then load");
        applyStimulus(1'b1, 1'b1, 32'h40, 32'hDEADBEEF, 1'b1);
        @(negedge clk);
        checkOutput("store_m_bus", {bus.m_req, bus.m_we, bus.m_addr, bus.m_wdata},
                    {1'b1, 1'b1, 32'h40, 32'hDEADBEEF});
        checkOutput("store_stall_M", bus.stall_M, 1);
        finishRequest(1'b1, "store");
        @(negedge clk);
        applyStimulus(1'b1, 1'b0, 32'h40, 32'h0, 1'b1);
        finishRequest(1'b1, "load");
        checkOutput("load_d_rdata_held", bus.d_rdata, 32'hDEADBEEF);

        $display("[TB] contention");
        force_lat = -1;
        for (int r = 0; r < 2; r++) begin
            repeat (2) @(negedge clk);
            grant_log.delete();
            fork
                begin
                    applyStimulus(1'b0, 1'b0, 32'h20, 32'h0, 1'b1);
                    finishRequest(1'b0, "cont_fetch");
                end
                begin
                    for (int k = 0; k < 5; k++) begin
                        applyStimulus(1'b1, 1'b0, 32'h300 + 32'(4 * k), 32'h0, 1'b1);
                        finishRequest(1'b1, "cont_data");
                        @(negedge clk);
                    end
                end
            join
            checkOutput("cont_grant_count", grant_log.size() >= 5, 1);
            for (int k = 0; k < 5 && k < grant_log.size(); k++)
                checkOutput($sformatf("cont_grant_%0d_%0d", r, k), grant_log[k], (k == 4) ? 1 : 0);
        end

        $display("[TB] flush");
        repeat (2) @(negedge clk);
        force_lat   = 2;
        mreq_cycles = 0;
        applyStimulus(1'b0, 1'b0, 32'h24, 32'h0, 1'b0);
        waitFetchMreq(32'h24, "flush_grant");
        bus.i_flush = 1'b1;
        @(negedge clk);
        bus.i_flush = 1'b0;
        bus.i_req   = 1'b0;
        repeat (6) @(negedge clk);
        checkOutput("flush_m_req_cycles", mreq_cycles, 3);
        force_lat = -1;
        applyStimulus(1'b0, 1'b0, 32'h28, 32'h0, 1'b1);
        finishRequest(1'b0, "post_flush_fetch");

        $display("[TB] memory wait");
        @(negedge clk);
        force_lat   = 5;
        mreq_cycles = 0;
        applyStimulus(1'b1, 1'b1, 32'h48, $urandom, 1'b1);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            checkOutput("wait_m_req", bus.m_req, 1);
            checkOutput("wait_stall_M", bus.stall_M, 1);
        end
        finishRequest(1'b1, "wait_store");
        checkOutput("wait_m_req_cycles", mreq_cycles, 6);

        $display("[TB] async reset mid-fetch");
        @(negedge clk);
        applyStimulus(1'b0, 1'b0, 32'h30, 32'h0, 1'b1);
        waitFetchMreq(32'h30, "reset_grant");
        #2;
        rst       = 1'b1;
        bus.i_req = 1'b0;
        #1;
        checkOutput("areset_m_req", bus.m_req, 0);
        checkOutput("areset_m_bus", {bus.m_we, bus.m_addr, bus.m_wdata}, 0);
        checkOutput("areset_valids", {bus.i_valid, bus.d_valid}, 0);
        checkOutput("areset_rdata", {bus.i_rdata, bus.d_rdata}, 0);
        checkOutput("areset_stalls", {bus.stall_F, bus.stall_M}, 0);
        i_exp_q.delete();
        d_exp_q.delete();
        last_load = 32'h0;
        @(negedge clk);
        @(negedge clk);
        rst       = 1'b0;
        force_lat = -1;
        @(negedge clk);
        applyStimulus(1'b0, 1'b0, 32'h34, 32'h0, 1'b1);
        finishRequest(1'b0, "post_reset_fetch");

        $display("[TB] randomized traffic");
        fork
            fetchDriver(40);
            dataDriver(40);
        join
        repeat (10) @(negedge clk);
        checkOutput("i_queue_drained", i_exp_q.size(), 0);
        checkOutput("d_queue_drained", d_exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
